// File: rtl/window_accumulator_if.sv
// Handshake/data bundle for window_accumulator: sample stream in, window result out.
interface window_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 12
);
  logic                 start;
  logic                 cont;
  logic                 en;
  logic [WIDTH-1:0]     din;
  logic [ACC_WIDTH-1:0] sum;
  logic                 done;
  logic                 sat;
  logic                 busy;

  modport master (output start, cont, en, din, input sum, done, sat, busy);
  modport slave  (input start, cont, en, din, output sum, done, sat, busy);
endinterface

// File: rtl/window_accumulator.sv
// Signed windowed accumulator: sums NSAMP en-qualified samples and strobes done with the sum.
// Optional clamping of the running sum is built when WINDOW_ACC_SAT_EN is defined.
module window_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 12,
  parameter int NSAMP     = 16
) (
  input logic              clk,
  input logic              rstb,
  window_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(NSAMP);
  localparam int MSB   = ACC_WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSAMP - 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t               state_reg;
  logic [ACC_WIDTH-1:0] acc_reg;
  logic [ACC_WIDTH-1:0] sum_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 done_reg;
  logic [ACC_WIDTH-1:0] din_ext;
  logic [ACC_WIDTH-1:0] add_raw;
  logic [ACC_WIDTH-1:0] add_res;
  logic                 accept;
  logic                 complete;

  genvar gi;
  generate
    for (gi = 0; gi < ACC_WIDTH; gi++) begin : g_sext
      if (gi < WIDTH) begin : g_bit
        assign din_ext[gi] = bus.din[gi];
      end else begin : g_sign
        assign din_ext[gi] = bus.din[WIDTH-1];
      end
    end
  endgenerate

  assign accept   = (state_reg == ACC) && bus.en;
  assign complete = accept && (cnt_reg == CNT_LAST);
  assign add_raw  = acc_reg + din_ext;

`ifdef WINDOW_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic satw_reg;
  logic sat_reg;
  logic ovf;
  logic win_sat;

  // Overflow only when both operands share a sign and the result flips it.
  assign ovf     = (acc_reg[MSB] == din_ext[MSB]) && (add_raw[MSB] != acc_reg[MSB]);
  assign add_res = ovf ? (acc_reg[MSB] ? ACC_MIN : ACC_MAX) : add_raw;
  assign win_sat = satw_reg | ovf;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      satw_reg <= 1'b0;
      sat_reg  <= 1'b0;
    end else begin
      if (complete)
        sat_reg <= win_sat;
      if (complete || bus.start)
        satw_reg <= 1'b0;
      else if (accept)
        satw_reg <= win_sat;
    end
  end

  assign bus.sat = sat_reg;
`else
  assign add_res = add_raw;
  assign bus.sat = 1'b0;
`endif

  // Completion outranks start so a coincident start still publishes the window.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (complete) begin
        sum_reg   <= add_res;
        done_reg  <= 1'b1;
        acc_reg   <= '0;
        cnt_reg   <= '0;
        state_reg <= (bus.cont || bus.start) ? ACC : IDLE;
      end else if (bus.start) begin
        state_reg <= ACC;
        acc_reg   <= '0;
        cnt_reg   <= '0;
      end else if (accept) begin
        acc_reg <= add_res;
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.sum  = sum_reg;
  assign bus.done = done_reg;
  assign bus.busy = (state_reg == ACC);
endmodule

// File: tb/tb_window_accumulator.sv
// Bench for window_accumulator: a 12-bit and a 9-bit accumulator share one stimulus stream
// and are compared against a queue-based window model.
module tb_window_accumulator;
  localparam int NSAMP = 4;

  logic clk;
  logic rstb;
  int   checks;
  int   errors;

  window_accumulator_if #(.WIDTH(8), .ACC_WIDTH(12)) b12 ();
  window_accumulator_if #(.WIDTH(8), .ACC_WIDTH(9))  b9  ();

  window_accumulator #(.WIDTH(8), .ACC_WIDTH(12), .NSAMP(NSAMP)) u12 (
    .clk  (clk),
    .rstb (rstb),
    .bus  (b12)
  );
  window_accumulator #(.WIDTH(8), .ACC_WIDTH(9), .NSAMP(NSAMP)) u9 (
    .clk  (clk),
    .rstb (rstb),
    .bus  (b9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accepted samples of the open window, folded on completion.
  bit m_busy;
  bit m_done;
  int m_sum12;
  int m_sum9;
  bit m_sat12;
  bit m_sat9;
  int q[$];

  function automatic void fold(input int w, output int s, output bit st);
    int half;
    int a;
    half = 1 << (w - 1);
    a    = 0;
    st   = 1'b0;
    foreach (q[i]) begin
      a += q[i];
`ifdef WINDOW_ACC_SAT_EN
      if (a > half - 1) begin
        a  = half - 1;
        st = 1'b1;
      end else if (a < -half) begin
        a  = -half;
        st = 1'b1;
      end
`else
      a = ((a + half) % (2 * half) + 2 * half) % (2 * half) - half;
`endif
    end
    s = a;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0;
    m_sum12 = 0; m_sum9 = 0; m_sat12 = 0; m_sat9 = 0;
    q.delete();
  endtask

  task automatic model_edge(input bit st, input bit co, input bit e, input int d);
    if (!m_busy) begin
      m_done = 0;
      if (st) begin
        m_busy = 1;
        q.delete();
      end
    end else if (e && q.size() == NSAMP - 1) begin
      q.push_back(d);
      fold(12, m_sum12, m_sat12);
      fold(9, m_sum9, m_sat9);
      m_done = 1;
      q.delete();
      m_busy = co || st;
    end else begin
      m_done = 0;
      if (st) q.delete();
      else if (e) q.push_back(d);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " done12"}, int'(b12.done), int'(m_done));
    chk({tag, " busy12"}, int'(b12.busy), int'(m_busy));
    chk({tag, " sum12"},  int'($signed(b12.sum)), m_sum12);
    chk({tag, " sat12"},  int'(b12.sat), int'(m_sat12));
    chk({tag, " done9"},  int'(b9.done), int'(m_done));
    chk({tag, " busy9"},  int'(b9.busy), int'(m_busy));
    chk({tag, " sum9"},   int'($signed(b9.sum)), m_sum9);
    chk({tag, " sat9"},   int'(b9.sat), int'(m_sat9));
  endtask

  task automatic drive(input bit st, input bit co, input bit e, input logic [7:0] d);
    b12.start = st; b12.cont = co; b12.en = e; b12.din = d;
    b9.start  = st; b9.cont  = co; b9.en  = e; b9.din  = d;
  endtask

  task automatic step(input string tag, input bit st, input bit co, input bit e,
                      input logic [7:0] d);
    drive(st, co, e, d);
    @(posedge clk);
    model_edge(st, co, e, int'($signed(d)));
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] r;
    checks = 0;
    errors = 0;
    rstb   = 1'b0;
    drive(0, 0, 0, 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2 rstb = 1'b1;

    // Basic window
    step("basic_start", 1, 0, 0, 8'd0);
    step("basic_s1", 0, 0, 1, 8'd10);
    step("basic_s2", 0, 0, 1, 8'd20);
    step("basic_s3", 0, 0, 1, 8'd30);
    step("basic_s4", 0, 0, 1, 8'd40);
    chk("basic_sum_const", int'($signed(b12.sum)), 100);
    step("basic_after", 0, 0, 0, 8'd0);

    // Gapped EN, with EN asserted in the START cycle
    step("gap_start", 1, 0, 1, 8'd99);
    step("gap_a", 0, 0, 1, 8'hFB);
    for (int i = 0; i < 3; i++) begin
      step("gap_idle", 0, 0, 0, 8'd7);
      step("gap_idle", 0, 0, 0, 8'd7);
      step("gap_s", 0, 0, 1, (i == 0) ? 8'd3 : 8'hFF);
    end
    chk("gap_sum_const", int'(b12.sum), 32'h0000_0FFC);

    // Saturation pattern (9-bit instance exercises the clamp)
    step("sat_start", 1, 0, 0, 8'd0);
    step("sat_s1", 0, 0, 1, 8'd100);
    step("sat_s2", 0, 0, 1, 8'd100);
    step("sat_s3", 0, 0, 1, 8'd100);
    step("sat_s4", 0, 0, 1, 8'h80);
`ifdef WINDOW_ACC_SAT_EN
    chk("sat_sum9_const", int'($signed(b9.sum)), 127);
    chk("sat_flag9_const", int'(b9.sat), 1);
`else
    chk("sat_sum9_const", int'($signed(b9.sum)), 172);
    chk("sat_flag9_const", int'(b9.sat), 0);
`endif

    // Continuous mode
    step("cont_start", 1, 1, 0, 8'd0);
    for (int i = 0; i < 12; i++) step("cont_s", 0, 1, 1, 8'd1);
    step("cont_stop", 0, 0, 0, 8'd0);

    // Restart mid-window, START coincident with EN
    step("rs_start", 1, 0, 0, 8'd0);
    step("rs_s1", 0, 0, 1, 8'd50);
    step("rs_s2", 0, 0, 1, 8'd50);
    step("rs_restart", 1, 0, 1, 8'd50);
    for (int i = 0; i < 4; i++) step("rs_s", 0, 0, 1, 8'd1);
    chk("rs_sum_const", int'($signed(b12.sum)), 4);

    // Asynchronous reset mid-window
    step("ar_start", 1, 0, 0, 8'd0);
    for (int i = 0; i < 3; i++) step("ar_s", 0, 0, 1, 8'd9);
    #2 rstb = 1'b0;
    #1;
    model_reset();
    check_all("ar_async");
    step("ar_held", 0, 0, 1, 8'd9);
    #2 rstb = 1'b1;
    for (int i = 0; i < 3; i++) step("ar_after", 0, 0, 1, 8'd9);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom);
      step("rand", $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_accumulator.md
# window_accumulator

Parametrised signed windowed accumulator for the estimator datapath. It sums a fixed number of EN-qualified samples and publishes the window sum with a one-cycle DONE strobe. It can re-arm automatically for back-to-back windows, and it optionally saturates the running sum. It sits between the sample front-end and the estimator arithmetic, and replaces hand-built chains of flops and adders with a single configurable register-transfer block.

## Interface
Parameters:
- WIDTH, 8: DIN width, two's complement.
- ACC_WIDTH, 12: accumulator and SUM width, two's complement; must be ≥ WIDTH.
- NSAMP, 16: samples per window; must be ≥ 2.

Ports:
- CLK  in  1  rising-edge clock; the block's only clock.
- RSTB  in  1  asynchronous active-low reset.
- START  in  1  single-cycle pulse that opens a window.
- CONT  in  1  1 = re-arm automatically after each window.
- EN  in  1  sample-valid qualifier for DIN.
- DIN  in  WIDTH  sample, signed.
- SUM  out  ACC_WIDTH  registered window sum, signed.
- DONE  out  1  one-cycle strobe; SUM and SAT are valid in that cycle.
- SAT  out  1  1 = the published window saturated at least once.
- BUSY  out  1  high while a window is open.

## Operation
- State machine, two states:
  - IDLE → ACC when START = 1.
  - ACC → IDLE on window completion when CONT = 0.
  - ACC → ACC on window completion when CONT = 1.
- Internal registers: ACC (ACC_WIDTH bits), CNT (clog2(NSAMP) bits), sticky window flag SATW.
- A sample is accepted only when the state is ACC and EN = 1. EN is ignored in IDLE, including in the START cycle.
- On each accepted sample:
  - DIN is sign-extended to ACC_WIDTH and added to ACC.
  - CNT increments by 1.
- Window completion is the accepted sample with CNT = NSAMP-1. On that edge:
  - SUM ← ACC + DIN, after overflow handling.
  - SAT ← SATW, including any overflow on this sample.
  - DONE ← 1.
  - ACC, CNT and SATW clear to 0.
- START while in ACC restarts the window: ACC, CNT and SATW clear, and a coincident EN sample is discarded.
- START coinciding with window completion: the completion is published, then a fresh window opens regardless of CONT.
- SUM and SAT hold their values until the next completion. DONE is high for exactly one cycle per window.
- BUSY = (state == ACC).

## Timing
- Reset values:
  - SUM = 0, DONE = 0, SAT = 0, BUSY = 0.
  - ACC = 0, CNT = 0, SATW = 0, state = IDLE.
- Asserting RSTB low mid-window aborts the window immediately and asynchronously. No DONE is produced.
- START at edge k makes BUSY = 1 after edge k. The first sample can be accepted at edge k+1.
- The final sample accepted at edge n makes DONE = 1 and SUM valid after edge n; DONE returns to 0 after edge n+1.
- With CONT = 1 there are no dead cycles between windows. A sample at edge n+1 belongs to the next window.
- Minimum window length is NSAMP cycles with EN held high. EN gaps stretch the window without limit.

## Configuration
- Macro: WINDOW_ACC_SAT_EN.
- Defined:
  - Each addition is checked for signed overflow.
  - Results clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - SATW sets on any clamp and is reported through SAT.
- Undefined:
  - Additions wrap modulo 2^ACC_WIDTH.
  - SATW and the clamp logic are not built; SAT is tied to 0.

## Test plan
All scenarios use WIDTH = 8, ACC_WIDTH = 12, NSAMP = 4 unless stated otherwise.
- Basic window: START, then EN continuous with DIN = 10, 20, 30, 40 → DONE pulses once after the 4th edge, SUM = 100, SAT = 0, BUSY falls in the same cycle as DONE.
- Gapped EN: samples -5, 3, -1, -1 with two EN-low cycles between each → SUM = 0xFFC (-4); DONE occurs only after the 4th accepted sample; EN in the START cycle is ignored.
- Saturation, with ACC_WIDTH = 9 and DIN = 100, 100, 100, -128:
  - Macro defined → running sums 100, 200, 255 (clamped), 127; SUM = 127, SAT = 1.
  - Macro undefined → SUM = 172, SAT = 0.
- Continuous mode: CONT = 1 with 12 consecutive samples of value 1 → three DONE pulses exactly 4 cycles apart, SUM = 4 each time, BUSY stays high throughout.
- Restart and reset:
  - Two samples of 50, then START, then 4 samples of 1 → SUM = 4.
  - RSTB pulsed low after 3 samples → all outputs are 0 immediately and no DONE appears.
